// File: rtl/regfile_pkg.sv
// Shared types and constants for the RegisterFile writeback path.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_WIDTH  = 64;
  localparam int ZERO_REG   = 31;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_WIDTH-1:0]  data;
  } wb_req_t;

  typedef enum logic {
    PREF_REQ0 = 1'b0,
    PREF_REQ1 = 1'b1
  } rr_pref_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small circular FIFO of writeback requests; exposes every slot's valid/addr so the
// top level can build the Pending scoreboard without reading entries out.
module regfile_wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                 Clk,
  input  logic                                 Rst_n,
  input  logic                                 push,
  input  wb_req_t                              pushReq,
  input  logic                                 pop,
  output wb_req_t                              head,
  output logic                                 full,
  output logic                                 empty,
  output logic [DEPTH-1:0]                     entryValid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entryAddr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] offset [DEPTH];
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= pushReq;
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offset[i]     = PTR_W'(i) - rdPtr;
      entryValid[i] = {1'b0, offset[i]} < count;
      entryAddr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the RegisterFile write port between the ALU (req0)
// and load (req1) writeback streams, with a per-register Pending vector.
module regfile_wb_arbiter #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 31
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req0Valid,
  input  logic [ADDR_W-1:0] Req0Addr,
  input  logic [WIDTH-1:0]  Req0Data,
  output logic              Req0Ready,
  input  logic              Req1Valid,
  input  logic [ADDR_W-1:0] Req1Addr,
  input  logic [WIDTH-1:0]  Req1Data,
  output logic              Req1Ready,
  output logic [ADDR_W-1:0] RW,
  output logic [WIDTH-1:0]  BusW,
  output logic              RegWr,
  output logic [31:0]       Pending
);

  regfile_pkg::wb_req_t  head0, head1;
  regfile_pkg::rr_pref_t rrPref;
  logic full0, full1, empty0, empty1;
  logic push0, push1, grant0, grant1;
  logic [DEPTH-1:0]                             entryValid0, entryValid1;
  logic [DEPTH-1:0][regfile_pkg::REG_ADDR_W-1:0] entryAddr0, entryAddr1;

  assign Req0Ready = !full0;
  assign Req1Ready = !full1;

  // Zero-register writes are consumed here so they never occupy a slot.
  assign push0 = Req0Valid && Req0Ready && (Req0Addr != ADDR_W'(ZERO_REG));
  assign push1 = Req1Valid && Req1Ready && (Req1Addr != ADDR_W'(ZERO_REG));

  regfile_wb_fifo #(.DEPTH(DEPTH)) fifo0 (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .push       (push0),
    .pushReq    ({Req0Addr, Req0Data}),
    .pop        (grant0),
    .head       (head0),
    .full       (full0),
    .empty      (empty0),
    .entryValid (entryValid0),
    .entryAddr  (entryAddr0)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH)) fifo1 (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .push       (push1),
    .pushReq    ({Req1Addr, Req1Data}),
    .pop        (grant1),
    .head       (head1),
    .full       (full1),
    .empty      (empty1),
    .entryValid (entryValid1),
    .entryAddr  (entryAddr1)
  );

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!empty0 && !empty1) begin
      if (rrPref == regfile_pkg::PREF_REQ1) grant1 = 1'b1;
      else                                  grant0 = 1'b1;
    end else if (!empty0) begin
      grant0 = 1'b1;
    end else if (!empty1) begin
      grant1 = 1'b1;
    end
  end

  // The loser of a grant gets priority next time; no grant leaves the pointer alone.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rrPref <= regfile_pkg::PREF_REQ0;
      RW     <= '0;
      BusW   <= '0;
      RegWr  <= 1'b0;
    end else begin
      RegWr <= grant0 || grant1;
      if (grant0) begin
        rrPref <= regfile_pkg::PREF_REQ1;
        RW     <= head0.addr;
        BusW   <= head0.data;
      end else if (grant1) begin
        rrPref <= regfile_pkg::PREF_REQ0;
        RW     <= head1.addr;
        BusW   <= head1.data;
      end
    end
  end

  always_comb begin
    Pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid0[i]) Pending[entryAddr0[i]] = 1'b1;
      if (entryValid1[i]) Pending[entryAddr1[i]] = 1'b1;
    end
    if (RegWr) Pending[RW] = 1'b1;
    Pending[ZERO_REG] = 1'b0;
  end

endmodule
